// File: rtl/viterbi_decoder_pkg.sv
// Shared definitions for the K=3, rate-1/2 Viterbi decoder: FSM encoding,
// metric sizing, generator taps and small arithmetic helpers.
package viterbi_decoder_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StCompute = 3'd2,
        StTrace   = 3'd3,
        StDone    = 3'd4
    } state_e;

    localparam int unsigned NumStates = 4;
    localparam int unsigned MetricW   = 5;
    localparam logic [MetricW-1:0] MetricMax = 5'd31;

    // Generator taps over {u, s1, s0}: 7 and 5 octal
    localparam logic [2:0] Gen0 = 3'b111;
    localparam logic [2:0] Gen1 = 3'b101;

    typedef logic [NumStates-1:0][MetricW-1:0] metric_vec_t;
    typedef logic [NumStates-1:0][1:0]         flag_vec_t;

    // Encoder output {c0, c1} for input u leaving state s
    function automatic logic [1:0] branch_out(logic u, logic [1:0] s);
        logic [2:0] taps;
        taps = {u, s};
        return {^(taps & Gen0), ^(taps & Gen1)};
    endfunction

    function automatic logic [1:0] hamming(logic [1:0] a, logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

    function automatic logic [MetricW-1:0] add_sat(logic [MetricW-1:0] a, logic [1:0] b);
        logic [MetricW:0] s;
        s = {1'b0, a} + {{(MetricW - 1){1'b0}}, b};
        return (s > {1'b0, MetricMax}) ? MetricMax : s[MetricW-1:0];
    endfunction

    // Index of the smallest metric, lowest index wins ties
    function automatic logic [1:0] min_state(metric_vec_t m);
        logic [1:0] best;
        best = 2'd0;
        for (int i = 1; i < NumStates; i++) begin
            if (m[i] < m[best]) best = 2'(i);
        end
        return best;
    endfunction

endpackage

// File: rtl/viterbi_decoder_acs.sv
// Add-compare-select for all four trellis states in one stage.
module acs_unit
    import viterbi_decoder_pkg::*;
(
    input  logic [1:0]  sym,
    input  metric_vec_t metric_in,
    output metric_vec_t metric_out,
    output flag_vec_t   flag_out
);

    // State s={s1,s0} is reached from {s0,0} and {s0,1} with input u=s1
    always_comb begin
        metric_out = '0;
        flag_out   = '0;
        for (int s = 0; s < NumStates; s++) begin
            logic [1:0]         sv, pa, pb;
            logic [MetricW-1:0] sum_a, sum_b;
            sv    = 2'(s);
            pa    = {sv[0], 1'b0};
            pb    = {sv[0], 1'b1};
            sum_a = add_sat(metric_in[pa], hamming(sym, branch_out(sv[1], pa)));
            sum_b = add_sat(metric_in[pb], hamming(sym, branch_out(sv[1], pb)));
            if (sum_a <= sum_b) begin
                metric_out[s] = sum_a;
                flag_out[s]   = pa;
            end else begin
                metric_out[s] = sum_b;
                flag_out[s]   = pb;
            end
        end
    end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder: forward ACS pass into a survivor array,
// then a one-bit-per-cycle traceback from the best final state.
module viterbi_decoder
    import viterbi_decoder_pkg::*;
#(
    parameter int unsigned N = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st,
    input  logic [2*N+1:0]   code_in,
    output logic [N:0]       data_out,
    output logic             done,
    output logic [6:0]       ram_test0,
    output logic [6:0]       ram_test1,
    output logic [6:0]       ram_test2,
    output logic [6:0]       ram_test3,
    output logic             done_comp_test,
    output logic             done_compute_test,
    output logic             done_trk_test,
    output logic [1:0]       data_in_test,
    output logic [2:0]       state_test,
    output logic [1:0]       node_test,
    output logic [3:0]       base_addr_test,
    output logic [4:0]       cnt_test,
    output logic             data_out_trk_test,
    output logic [1:0]       flag_trk_test
);

    localparam int unsigned L     = N + 1;
    localparam int unsigned AddrW = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned CntW  = 5;

    state_e            state_q, state_d;
    logic [2*L-1:0]    code_q, code_d;
    metric_vec_t       metric_q, metric_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        node_q, node_d;
    logic [L-1:0]      data_out_q, data_out_d;
    logic              done_q, done_d;
    logic [6:0]        ram_q [L][NumStates];
    logic              ram_we;
    logic [AddrW-1:0]  addr;
    logic [1:0]        sym;
    metric_vec_t       acs_metric;
    flag_vec_t         acs_flag;
    logic [1:0]        trk_flag;
    logic              last_stage;
    logic              first_stage;

    assign addr        = cnt_q[AddrW-1:0];
    assign last_stage  = (cnt_q == CntW'(N));
    assign first_stage = (cnt_q == '0);
    assign trk_flag    = ram_q[addr][node_q][1:0];

    // Pick the received symbol for the current stage
    always_comb begin
        sym = '0;
        for (int i = 0; i < L; i++) begin
            if (cnt_q == CntW'(i)) sym = code_q[2*i +: 2];
        end
    end

    acs_unit u_acs (
        .sym        (sym),
        .metric_in  (metric_q),
        .metric_out (acs_metric),
        .flag_out   (acs_flag)
    );

    // Next-state logic for the decode sequence
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        metric_d   = metric_q;
        cnt_d      = cnt_q;
        node_d     = node_q;
        data_out_d = data_out_q;
        ram_we     = 1'b0;
        // Registered so done trails entry into StDone by one clock
        done_d     = (state_q == StDone) && !st;
        case (state_q)
            StIdle: begin
                if (st) begin
                    state_d = StLoad;
                    code_d  = code_in;
                end
            end
            StLoad: begin
                for (int s = 1; s < NumStates; s++) metric_d[s] = MetricMax;
                metric_d[0] = '0;
                cnt_d       = '0;
                state_d     = StCompute;
            end
            StCompute: begin
                metric_d = acs_metric;
                ram_we   = 1'b1;
                if (last_stage) begin
                    node_d  = min_state(acs_metric);
                    state_d = StTrace;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StTrace: begin
                data_out_d[addr] = node_q[1];
                node_d           = trk_flag;
                if (first_stage) state_d = StDone;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StDone: begin
                if (st) begin
                    state_d = StLoad;
                    code_d  = code_in;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            code_q     <= '0;
            metric_q   <= '0;
            cnt_q      <= '0;
            node_q     <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            metric_q   <= metric_d;
            cnt_q      <= cnt_d;
            node_q     <= node_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

    // Survivor array: {metric, predecessor} per state per stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < L; t++) begin
                for (int s = 0; s < NumStates; s++) ram_q[t][s] <= '0;
            end
        end else if (ram_we) begin
            for (int s = 0; s < NumStates; s++) ram_q[addr][s] <= {acs_metric[s], acs_flag[s]};
        end
    end

    // Result and debug views
    always_comb begin
        data_out          = data_out_q;
        done              = done_q;
        ram_test0         = ram_q[addr][0];
        ram_test1         = ram_q[addr][1];
        ram_test2         = ram_q[addr][2];
        ram_test3         = ram_q[addr][3];
        done_comp_test    = (state_q == StCompute);
        done_compute_test = (state_q == StCompute) && last_stage;
        done_trk_test     = (state_q == StTrace) && first_stage;
        data_in_test      = (state_q == StCompute) ? sym : 2'b00;
        state_test        = state_q;
        node_test         = node_q;
        base_addr_test    = 4'(cnt_q);
        cnt_test          = cnt_q;
        data_out_trk_test = (state_q == StTrace) && node_q[1];
        flag_trk_test     = (state_q == StTrace) ? trk_flag : 2'b00;
    end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed bench for viterbi_decoder with a reference convolutional encoder.
module tb_viterbi_decoder;

    localparam int N   = 9;
    localparam int L   = N + 1;
    localparam int Lat = 2 * L + 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           st  = 1'b0;
    logic [2*L-1:0] code_in = '0;
    logic [L-1:0]   data_out;
    logic           done;
    logic [6:0]     ram_test0, ram_test1, ram_test2, ram_test3;
    logic           done_comp_test, done_compute_test, done_trk_test;
    logic [1:0]     data_in_test;
    logic [2:0]     state_test;
    logic [1:0]     node_test;
    logic [3:0]     base_addr_test;
    logic [4:0]     cnt_test;
    logic           data_out_trk_test;
    logic [1:0]     flag_trk_test;

    int n_checks = 0;
    int n_fails  = 0;

    viterbi_decoder #(.N(N)) dut (
        .clk               (clk),
        .rst               (rst),
        .st                (st),
        .code_in           (code_in),
        .data_out          (data_out),
        .done              (done),
        .ram_test0         (ram_test0),
        .ram_test1         (ram_test1),
        .ram_test2         (ram_test2),
        .ram_test3         (ram_test3),
        .done_comp_test    (done_comp_test),
        .done_compute_test (done_compute_test),
        .done_trk_test     (done_trk_test),
        .data_in_test      (data_in_test),
        .state_test        (state_test),
        .node_test         (node_test),
        .base_addr_test    (base_addr_test),
        .cnt_test          (cnt_test),
        .data_out_trk_test (data_out_trk_test),
        .flag_trk_test     (flag_trk_test)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference (7,5) encoder starting from state 0
    function automatic logic [2*L-1:0] encode(logic [L-1:0] m);
        logic [2*L-1:0] c;
        logic [1:0]     s;
        c = '0;
        s = 2'b00;
        for (int i = 0; i < L; i++) begin
            c[2*i+1] = m[i] ^ s[1] ^ s[0];
            c[2*i]   = m[i] ^ s[0];
            s        = {m[i], s[1]};
        end
        return c;
    endfunction

    function automatic logic [4:0] min4(logic [4:0] a, logic [4:0] b, logic [4:0] c,
                                        logic [4:0] d);
        logic [4:0] m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        if (d < m) m = d;
        return m;
    endfunction

    // Pulse st with the given code, then run until done or a cycle budget expires
    task automatic run_decode(input logic [2*L-1:0] code, input bit poke, output int lat,
                              output logic [4:0] m0, output logic [4:0] minm,
                              output int ncomp, output bit dropped);
        bit poked;
        code_in = code;
        @(negedge clk);
        st = 1'b1;
        @(posedge clk);
        #1;
        st      = 1'b0;
        dropped = !done;
        lat     = 0;
        m0      = 5'h1f;
        minm    = 5'h1f;
        ncomp   = 0;
        poked   = 1'b0;
        while (lat < 100 && !done) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_comp_test) ncomp++;
            if (state_test == 3'd3 && cnt_test == 5'(N)) begin
                m0   = ram_test0[6:2];
                minm = min4(ram_test0[6:2], ram_test1[6:2], ram_test2[6:2], ram_test3[6:2]);
            end
            if (poke && state_test == 3'd3 && !poked) begin
                st    = 1'b1;
                poked = 1'b1;
            end else begin
                st = 1'b0;
            end
        end
        st = 1'b0;
    endtask

    initial begin
        int             lat, ncomp;
        logic [4:0]     m0, minm;
        bit             dropped;
        logic [2*L-1:0] code;
        logic [L-1:0]   msg, msg_b;

        // Reset state
        #12;
        check("rst_state", 32'(state_test), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_ram0", 32'(ram_test0), 32'd0);
        check("rst_cnt", 32'(cnt_test), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // All-zero codeword
        run_decode('0, 1'b0, lat, m0, minm, ncomp, dropped);
        check("zero_latency", 32'(lat), 32'(Lat));
        check("zero_data", 32'(data_out), 32'd0);
        check("zero_metric0", 32'(m0), 32'd0);
        check("zero_ncomp", 32'(ncomp), 32'(L));

        // Impulse on message bit 0
        code = '0;
        code[5:0] = 6'b111011;
        run_decode(code, 1'b0, lat, m0, minm, ncomp, dropped);
        check("impulse_data", 32'(data_out), 32'h001);
        check("impulse_minm", 32'(minm), 32'd0);

        // Same with one flipped channel bit
        code[0] = 1'b0;
        run_decode(code, 1'b0, lat, m0, minm, ncomp, dropped);
        check("flip_data", 32'(data_out), 32'h001);
        check("flip_minm", 32'(minm), 32'd1);

        // Asynchronous reset in the middle of COMPUTE
        code_in = encode(10'h2b5);
        @(negedge clk);
        st = 1'b1;
        @(posedge clk);
        #1;
        st = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("midrst_pre_state", 32'(state_test), 32'd2);
        rst = 1'b0;
        #1;
        check("midrst_state", 32'(state_test), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_data", 32'(data_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_decode(encode(10'h2b5), 1'b0, lat, m0, minm, ncomp, dropped);
        check("midrst_redo_data", 32'(data_out), 32'h2b5);
        check("midrst_redo_lat", 32'(lat), 32'(Lat));

        // st during TRACE is ignored; st in DONE restarts with new code
        msg   = 10'h1c6;
        msg_b = 10'h339;
        run_decode(encode(msg), 1'b1, lat, m0, minm, ncomp, dropped);
        check("poke_data", 32'(data_out), 32'(msg));
        check("poke_lat", 32'(lat), 32'(Lat));
        run_decode(encode(msg_b), 1'b0, lat, m0, minm, ncomp, dropped);
        check("restart_drop", 32'(dropped), 32'd1);
        check("restart_data", 32'(data_out), 32'(msg_b));
        check("restart_lat", 32'(lat), 32'(Lat));

        // Random error-free messages
        for (int r = 0; r < 4; r++) begin
            msg = 10'($urandom);
            run_decode(encode(msg), 1'b0, lat, m0, minm, ncomp, dropped);
            check("random_data", 32'(data_out), 32'(msg));
            check("random_minm", 32'(minm), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
